l2_port_arbiter: RTL

Two-port round-robin arbiter that shares the single L2 cache command port between the instruction-side and data-side L1 caches. It latches one L1 request at a time, issues it to L2 as a one-cycle command pulse, and holds the address and write data stable until L2 responds. It then returns the block, the hit flag and a one-cycle ready pulse to the granted L1. Per-port grant counters support performance monitoring.

---
 rtl/l2_port_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/l2_port_arbiter.sv
// Two-port round-robin arbiter sharing one L2 command port between the
// I-side (port 0) and D-side (port 1) L1 caches, with per-port grant counters.
module l2_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int L1_BLOCK_SIZE = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [ADDR_WIDTH-1:0]                    i_req0_addr,
  input  logic [ADDR_WIDTH-1:0]                    i_req1_addr,
  input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] i_req0_wdata,
  input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] i_req1_wdata,
  input  logic                                     i_req0_read,
  input  logic                                     i_req0_write,
  input  logic                                     i_req1_read,
  input  logic                                     i_req1_write,
  output logic                                     o_req0_ready,
  output logic                                     o_req1_ready,
  output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] o_req0_rdata,
  output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] o_req1_rdata,
  output logic                                     o_req0_hit,
  output logic                                     o_req1_hit,
  output logic [ADDR_WIDTH-1:0]                    o_l2_addr,
  output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] o_l2_wdata,
  output logic                                     o_l2_read,
  output logic                                     o_l2_write,
  input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] i_l2_rdata,
  input  logic                                     i_l2_ready,
  input  logic                                     i_l2_hit,
  output logic [CNT_WIDTH-1:0]                     o_grant_cnt0,
  output logic [CNT_WIDTH-1:0]                     o_grant_cnt1
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t                                   r_state;
  logic                                     r_lastGrant;
  logic                                     r_gntId;
  logic                                     r_opWrite;
  logic [ADDR_WIDTH-1:0]                    r_addr;
  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] r_wdata;
  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] r_rdata0;
  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] r_rdata1;
  logic                                     r_hit0;
  logic                                     r_hit1;
  logic                                     r_ready0;
  logic                                     r_ready1;
  logic [CNT_WIDTH-1:0]                     r_cnt0;
  logic [CNT_WIDTH-1:0]                     r_cnt1;

  logic w_pend0;
  logic w_pend1;
  logic w_grantValid;
  logic w_grantId;
  logic w_grantWrite;

  // A tie goes to the port that did not win last; a read+write on one port is a read.
  assign w_pend0      = i_req0_read | i_req0_write;
  assign w_pend1      = i_req1_read | i_req1_write;
  assign w_grantValid = w_pend0 | w_pend1;
  assign w_grantId    = (w_pend0 && w_pend1) ? ~r_lastGrant : w_pend1;
  assign w_grantWrite = w_grantId ? (i_req1_write & ~i_req1_read)
                                  : (i_req0_write & ~i_req0_read);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lastGrant <= 1'b1;
      r_gntId     <= 1'b0;
      r_opWrite   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_hit0      <= 1'b0;
      r_hit1      <= 1'b0;
      r_ready0    <= 1'b0;
      r_ready1    <= 1'b0;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
    end else begin
      r_ready0 <= 1'b0;
      r_ready1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grantValid) begin
            r_gntId     <= w_grantId;
            r_lastGrant <= w_grantId;
            r_opWrite   <= w_grantWrite;
            r_addr      <= w_grantId ? i_req1_addr : i_req0_addr;
            r_wdata     <= w_grantId ? i_req1_wdata : i_req0_wdata;
            if (w_grantId) begin
              if (r_cnt1 != '1) r_cnt1 <= r_cnt1 + CNT_WIDTH'(1);
            end else begin
              if (r_cnt0 != '1) r_cnt0 <= r_cnt0 + CNT_WIDTH'(1);
            end
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (i_l2_ready) begin
            if (r_gntId) begin
              r_rdata1 <= i_l2_rdata;
              r_hit1   <= i_l2_hit;
              r_ready1 <= 1'b1;
            end else begin
              r_rdata0 <= i_l2_rdata;
              r_hit0   <= i_l2_hit;
              r_ready0 <= 1'b1;
            end
            r_state <= S_RESPOND;
          end
        end
        S_RESPOND: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // The command pulse is decoded from the state so it lasts exactly the ISSUE cycle.
  assign o_l2_read    = (r_state == S_ISSUE) && !r_opWrite;
  assign o_l2_write   = (r_state == S_ISSUE) &&  r_opWrite;
  assign o_l2_addr    = r_addr;
  assign o_l2_wdata   = r_wdata;
  assign o_req0_ready = r_ready0;
  assign o_req1_ready = r_ready1;
  assign o_req0_rdata = r_rdata0;
  assign o_req1_rdata = r_rdata1;
  assign o_req0_hit   = r_hit0;
  assign o_req1_hit   = r_hit1;
  assign o_grant_cnt0 = r_cnt0;
  assign o_grant_cnt1 = r_cnt1;

endmodule
